// File: rtl/core_pkg.sv
// Core-wide constants shared by the pipeline stages (IF/ID/EXE).
package core_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0000;

endpackage : core_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures a fetched PC+4/instruction pair, with
// flush taking priority over freeze.
module if_id_register #(
    parameter int unsigned ADDR_W  = core_pkg::ADDR_W,
    parameter int unsigned INSTR_W = core_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               freeze,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [ADDR_W-1:0]  q_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic               q_valid
);

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    // A flush always inserts a bubble, even while the stage is frozen.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = '0;
            instr_d = INSTR_W'(core_pkg::INSTR_NOP);
            valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d    = d_pc;
            instr_d = d_instr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign q_pc    = pc_q;
    assign q_instr = instr_q;
    assign q_valid = valid_q;

endmodule : if_id_register

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses the zero-latency instruction memory and
// loads the IF/ID register; EXE branch redirect outranks ID freeze.
module instruction_fetch_stage #(
    parameter int unsigned       ADDR_W   = core_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = core_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(core_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic              unused_branch_lsbs;

    // Adder width equals ADDR_W, so the top word wraps to zero naturally.
    assign pc_plus4 = pc_q + ADDR_W'(core_pkg::PC_STEP);

    // Targets are word-aligned; the two byte-offset bits are discarded.
    assign branch_target      = {branch_addr[ADDR_W-1:2], 2'b00};
    assign unused_branch_lsbs = ^branch_addr[1:0];

    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (freeze) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_register #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (branch_taken),
        .freeze  (freeze),
        .d_pc    (pc_plus4),
        .d_instr (imem_instr),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

endmodule : instruction_fetch_stage
